// File: rtl/booth8_datapath_if.sv
// booth8_datapath_if
//   Bundles the controller <-> datapath strobes and result bus of the
//   radix-8 Booth multiplier.
//   master : controller side (drives strobes and operands, reads B/Product/Err)
//   slave  : datapath side  (reads strobes and operands, drives B/Product/Err)
//   Signals:
//     Load, Addc, Add, Shift, Count : operation strobes
//     Mcand, Mplier                 : WIDTH-bit signed operands
//     B                             : {digit is zero, all digits consumed}
//     Product                       : 2*WIDTH-bit signed product
//     Err                           : sticky 3M-not-ready error
interface booth8_datapath_if #(
  parameter int WIDTH = 12
);
  logic               Load;
  logic               Addc;
  logic               Add;
  logic               Shift;
  logic               Count;
  logic [WIDTH-1:0]   Mcand;
  logic [WIDTH-1:0]   Mplier;
  logic [1:0]         B;
  logic [2*WIDTH-1:0] Product;
  logic               Err;

  modport master (
    output Load, Addc, Add, Shift, Count, Mcand, Mplier,
    input  B, Product, Err
  );

  modport slave (
    input  Load, Addc, Add, Shift, Count, Mcand, Mplier,
    output B, Product, Err
  );
endinterface

// File: rtl/booth8_datapath.sv
// booth8_datapath
//   Radix-8 Booth multiplier datapath driven by an external controller FSM.
//   Holds multiplicand M, hard multiple 3M (with valid flag), accumulator,
//   multiplier shift register Q/Qm1 and the digit counter.
//   Ports:
//     Clock  : rising-edge clock
//     Resetn : asynchronous active-low reset
//     bus    : booth8_datapath_if.slave (strobes, operands, B, Product, Err)
//   Optional feature macro: BOOTH8_3M_CHECK_EN
//     defined   -> Err flags an Add with |d|==3 while 3M is not valid
//     undefined -> Err tied to 0, no check logic
module booth8_datapath #(
  parameter int WIDTH = 12
) (
  input  logic             Clock,
  input  logic             Resetn,
  booth8_datapath_if.slave bus
);
  localparam int NDIG = WIDTH / 3;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int AW   = WIDTH + 3;
  localparam int HW   = WIDTH + 2;
  localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);

  logic [WIDTH-1:0] m_r;
  logic [HW-1:0]    m3_r;
  logic             v3_r;
  logic [AW-1:0]    acc_r;
  logic [WIDTH-1:0] q_r;
  logic             qm1_r;
  logic [CW-1:0]    cnt_r;

  logic             neg_s;
  logic [2:0]       mag_s;
  logic [AW-1:0]    m_ext_s;
  logic [AW-1:0]    mult_s;
  logic [AW-1:0]    addend_s;
  logic [HW-1:0]    m3_sum_s;

  // Booth digit decode: sign and magnitude of d from {Q[2:0], Qm1}
  always_comb begin
    neg_s = 1'b0;
    mag_s = 3'd0;
    case ({q_r[2:0], qm1_r})
      4'b0000: begin neg_s = 1'b0; mag_s = 3'd0; end
      4'b0001: begin neg_s = 1'b0; mag_s = 3'd1; end
      4'b0010: begin neg_s = 1'b0; mag_s = 3'd1; end
      4'b0011: begin neg_s = 1'b0; mag_s = 3'd2; end
      4'b0100: begin neg_s = 1'b0; mag_s = 3'd2; end
      4'b0101: begin neg_s = 1'b0; mag_s = 3'd3; end
      4'b0110: begin neg_s = 1'b0; mag_s = 3'd3; end
      4'b0111: begin neg_s = 1'b0; mag_s = 3'd4; end
      4'b1000: begin neg_s = 1'b1; mag_s = 3'd4; end
      4'b1001: begin neg_s = 1'b1; mag_s = 3'd3; end
      4'b1010: begin neg_s = 1'b1; mag_s = 3'd3; end
      4'b1011: begin neg_s = 1'b1; mag_s = 3'd2; end
      4'b1100: begin neg_s = 1'b1; mag_s = 3'd2; end
      4'b1101: begin neg_s = 1'b1; mag_s = 3'd1; end
      4'b1110: begin neg_s = 1'b1; mag_s = 3'd1; end
      4'b1111: begin neg_s = 1'b0; mag_s = 3'd0; end
      default: begin neg_s = 1'b0; mag_s = 3'd0; end
    endcase
  end

  // Select |d|*M (shifted M or the 3M register) and apply the sign
  always_comb begin
    m_ext_s  = {{3{m_r[WIDTH-1]}}, m_r};
    m3_sum_s = {{2{m_r[WIDTH-1]}}, m_r} + {m_r[WIDTH-1], m_r, 1'b0};
    case (mag_s)
      3'd1:    mult_s = m_ext_s;
      3'd2:    mult_s = {m_ext_s[AW-2:0], 1'b0};
      3'd3:    mult_s = {m3_r[HW-1], m3_r};
      3'd4:    mult_s = {m_ext_s[AW-3:0], 2'b00};
      default: mult_s = {AW{1'b0}};
    endcase
    if (neg_s) begin
      addend_s = -mult_s;
    end else begin
      addend_s = mult_s;
    end
  end

  // Operand, hard-multiple, accumulator and shift-register state; one op per cycle
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_r   <= {WIDTH{1'b0}};
      m3_r  <= {HW{1'b0}};
      v3_r  <= 1'b0;
      acc_r <= {AW{1'b0}};
      q_r   <= {WIDTH{1'b0}};
      qm1_r <= 1'b0;
    end else if (bus.Load) begin
      m_r   <= bus.Mcand;
      v3_r  <= 1'b0;
      acc_r <= {AW{1'b0}};
      q_r   <= bus.Mplier;
      qm1_r <= 1'b0;
    end else if (bus.Addc) begin
      m3_r <= m3_sum_s;
      v3_r <= 1'b1;
    end else if (bus.Add) begin
      // d==0 yields a zero addend, so Acc holds
      acc_r <= acc_r + addend_s;
    end else if (bus.Shift) begin
      // {Acc, Q, Qm1} arithmetic right shift by one radix-8 digit
      acc_r <= {{3{acc_r[AW-1]}}, acc_r[AW-1:3]};
      q_r   <= {acc_r[2:0], q_r[WIDTH-1:3]};
      qm1_r <= q_r[2];
    end
  end

  // Digit counter: cleared by Load, saturates at NDIG
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_r <= {CW{1'b0}};
    end else if (bus.Load) begin
      cnt_r <= {CW{1'b0}};
    end else if (bus.Count && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

`ifdef BOOTH8_3M_CHECK_EN
  logic err_r;

  // Sticky error: an Add needed 3M before Addc made it valid
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      err_r <= 1'b0;
    end else if (bus.Load) begin
      err_r <= 1'b0;
    end else if (!bus.Addc && bus.Add && (mag_s == 3'd3) && !v3_r) begin
      err_r <= 1'b1;
    end
  end

  assign bus.Err = err_r;
`else
  assign bus.Err = 1'b0;
`endif

  assign bus.B       = {(mag_s == 3'd0), (cnt_r == CNT_MAX)};
  assign bus.Product = {acc_r[WIDTH-1:0], q_r};
endmodule

// File: doc/booth8_datapath.md
Name: booth8_datapath

Overview:
- Radix-8 Booth multiplier datapath for the sequential multiplier.
- Sits directly downstream of the multiplier controller FSM and consumes its Load/Addc/Add/Shift/Count strobes.
- Returns the 2-bit status bus B that the controller branches on.
- Holds the multiplicand, the precomputed 3M hard multiple, the accumulator and the multiplier shift register; produces a signed 2*WIDTH product.

Parameters:
- WIDTH, 12, operand width in bits; signed two's complement; must be a multiple of 3.
- NDIG, WIDTH/3, number of radix-8 digits (iterations); derived, not overridden.

Ports:
- Clock  input  1  rising-edge clock
- Resetn  input  1  asynchronous active-low reset
- Load  input  1  capture Mcand/Mplier, clear accumulator and counter
- Addc  input  1  compute 3M = M + 2M into the hard-multiple register
- Add  input  1  accumulate d*M, where d is the current Booth digit
- Shift  input  1  arithmetic shift right by 3 of {Acc, Q, Qm1}
- Count  input  1  increment the digit counter
- Mcand  input  WIDTH  signed multiplicand M
- Mplier  input  WIDTH  signed multiplier
- B  output  2  B[1] = current digit is zero; B[0] = all NDIG digits consumed
- Product  output  2*WIDTH  {Acc[WIDTH-1:0], Q}
- Err  output  1  sticky error (optional feature)

Behaviour:
- Registers:
  - M: WIDTH bits.
  - M3: WIDTH+2 bits, signed; V3 is its valid flag.
  - Acc: WIDTH+3 bits, signed.
  - Q: WIDTH bits.
  - Qm1: 1 bit.
  - Cnt: ceil(log2(NDIG+1)) bits.
- Reset (async, Resetn=0): all registers 0, V3=0, Err=0. Therefore B=2'b10 and Product=0.
- Digit: d = -4*Q[2] + 2*Q[1] + Q[0] + Qm1, range -4..+4. Combinational from current Q/Qm1.
- B[1] = (d==0). B[0] = (Cnt==NDIG). Both combinational from registers, no added latency.
- Operation priority per cycle: Load > Addc > Add > Shift. Only the highest-priority asserted op executes.
- Count is independent and may coincide with Shift or Add in the same cycle.
- Load: M<=Mcand, Q<=Mplier, Qm1<=0, Acc<=0, Cnt<=0, V3<=0. Count is ignored that cycle.
- Addc: M3<=sext(M)+sext(M<<1); V3<=1. One cycle.
- Add: Acc<=Acc + sext(d*M), all in WIDTH+3 bits.
  - |d| in {1,2,4}: multiple is M shifted 0/1/2.
  - |d|=3: multiple is M3.
  - Negative d: two's-complement negate of the multiple.
  - d=0: Acc unchanged.
- Shift: {Acc, Q, Qm1} <= arithmetic right shift by 3 (Acc sign bit replicated).
- Count: Cnt<=Cnt+1; saturates at NDIG (no wrap).
- Nominal controller sequence: Load; Addc; then NDIG times {Add if B[1]==0; Shift with Count}; stop when B[0]==1.
  - Total 2 + up to 2*NDIG cycles.
- Product = {Acc[WIDTH-1:0], Q}, valid when B[0]==1. It is not cleared until the next Load.
- No operation strobes asserted: all registers hold.
- Resetn asserted mid-operation: immediate clear to reset values. A fresh Load is required afterwards.
- Extra Shift after B[0]==1: executes; the product is corrupted. The controller must not issue it.

Optional Feature:
- Macro BOOTH8_3M_CHECK_EN.
- Defined: Err is set when Add executes with |d|==3 and V3==0. Err is cleared only by Load or reset. The Add still uses the stale M3 value.
- Not defined: Err is tied to 0 and no check logic is generated.

Test Plan:
- Reset then release with no strobes -> B=2'b10, Product=24'h000000, Err=0.
- Mcand=5, Mplier=3, nominal sequence -> first digit d=3 (B[1]=0); final B[0]=1, Product=24'h00000F.
- Mcand=-7, Mplier=3 -> Product=24'hFFFFEB (-21); check Acc sign extension through 4 shifts.
- Mcand=-2048, Mplier=-2048 -> Product=24'h400000. Then Mcand=2047, Mplier=-2048 -> Product=24'hC00800 (-4192256).
- Mplier=0 -> B[1]=1 every iteration, no Add issued, Product=0. After 5 Count pulses, Cnt stays at 4 and B[0]=1.
- BOOTH8_3M_CHECK_EN defined: Load (Mplier=3), skip Addc, Add -> Err=1 next cycle; next Load -> Err=0. Assert Resetn=0 mid-iteration -> all outputs at reset values.
